// File: rtl/pc_sequencer_if.sv
// Execute-to-fetch control bundle between the pipeline and the PC sequencer.
// The pipeline side drives the branch decision inputs; the sequencer drives the fetch side.
interface pc_sequencer_if #(
  parameter int DWIDTH = 32
);
  logic [6:0]        opcode_i;
  logic [2:0]        funct3_i;
  logic              breq_i;
  logic              brlt_i;
  logic [DWIDTH-1:0] target_i;
  logic              ex_valid_i;
  logic              stall_i;
  logic              imem_ready_i;
  logic              imem_req_o;
  logic [DWIDTH-1:0] pc_o;
  logic              flush_o;
  logic              misalign_o;
  logic [15:0]       taken_cnt_o;

  // Handshake: a fetch is accepted on a rising edge where imem_req_o and imem_ready_i are both high;
  // imem_req_o never depends on imem_ready_i, and the PC only advances on such an accepting edge.
  modport master (
    output opcode_i, funct3_i, breq_i, brlt_i, target_i, ex_valid_i, stall_i, imem_ready_i,
    input  imem_req_o, pc_o, flush_o, misalign_o, taken_cnt_o
  );

  modport slave (
    input  opcode_i, funct3_i, breq_i, brlt_i, target_i, ex_valid_i, stall_i, imem_ready_i,
    output imem_req_o, pc_o, flush_o, misalign_o, taken_cnt_o
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: resolves branches/jumps from execute, redirects the PC, and
// inserts a one-cycle flush bubble after every taken redirect.
module pc_sequencer #(
  parameter int                DWIDTH   = 32,
  parameter logic [DWIDTH-1:0] RESET_PC = 32'h0100_0000
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  pc_sequencer_if.slave  sq,
  output logic [1:0]     state_o
);

  localparam logic [6:0] BTYPE_OPCODE = 7'b1100011;
  localparam logic [6:0] JAL_OPCODE   = 7'b1101111;
  localparam logic [6:0] JALR_OPCODE  = 7'b1100111;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  state_t            state_q;
  logic [DWIDTH-1:0] pc_q;
  logic              flush_q;
  logic              misalign_q;
  logic [15:0]       cnt_q;

  logic              taken;
  logic              redirect;
  logic              advance;
  logic [15:0]       cnt_next;
  logic [DWIDTH-1:0] target_aligned;

  always_comb begin
    taken = 1'b0;
    case (sq.opcode_i)
      BTYPE_OPCODE: begin
        case (sq.funct3_i)
          3'b000:         taken = sq.breq_i;
          3'b001:         taken = !sq.breq_i;
          3'b100, 3'b110: taken = sq.brlt_i;
          3'b101, 3'b111: taken = !sq.brlt_i;
          default:        taken = 1'b0;
        endcase
      end
      JAL_OPCODE, JALR_OPCODE: taken = 1'b1;
      default:                 taken = 1'b0;
    endcase
  end

  // Redirect beats stall and imem backpressure; BUBBLE and BOOT ignore the branch inputs.
  assign redirect       = (state_q == RUN) && sq.ex_valid_i && taken;
  assign advance        = !sq.stall_i && sq.imem_ready_i;
  assign target_aligned = {sq.target_i[DWIDTH-1:2], 2'b00};
  assign cnt_next       = (redirect && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= 16'd0;
    end else begin
      flush_q <= 1'b0;
      cnt_q   <= cnt_next;
      case (state_q)
        BOOT: begin
          pc_q    <= RESET_PC;
          state_q <= RUN;
        end
        RUN: begin
          if (redirect) begin
            pc_q       <= target_aligned;
            flush_q    <= 1'b1;
            misalign_q <= misalign_q | (sq.target_i[1:0] != 2'b00);
            state_q    <= BUBBLE;
          end else if (advance) begin
            pc_q <= pc_q + DWIDTH'(4);
          end
        end
        BUBBLE: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= BOOT;
        end
      endcase
    end
  end

  assign sq.imem_req_o  = (state_q == RUN) && !sq.stall_i;
  assign sq.pc_o        = pc_q;
  assign sq.flush_o     = flush_q;
  assign sq.misalign_o  = misalign_q;
  assign sq.taken_cnt_o = cnt_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a branch-decode vector table plus hand-written
// sequences for boot, stall, misalignment, wrap, counter saturation and mid-bubble reset.
module tb_pc_sequencer;

  localparam logic [6:0]  OP_B    = 7'b1100011;
  localparam logic [6:0]  OP_JAL  = 7'b1101111;
  localparam logic [6:0]  OP_JALR = 7'b1100111;
  localparam logic [6:0]  OP_ALU  = 7'b0110011;
  localparam logic [31:0] RST_PC  = 32'h0100_0000;
  localparam logic [1:0]  S_BOOT  = 2'd0;
  localparam logic [1:0]  S_RUN   = 2'd1;
  localparam logic [1:0]  S_BUB   = 2'd2;

  logic       clk;
  logic       rst_n;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_pc;
  logic [15:0] m_cnt;

  pc_sequencer_if #(.DWIDTH(32)) sq ();

  pc_sequencer #(.DWIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .sq      (sq),
    .state_o (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        breq;
    logic        brlt;
    logic        ex_valid;
    logic [31:0] target;
    logic        exp_taken;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    sq.opcode_i     = 7'd0;
    sq.funct3_i     = 3'd0;
    sq.breq_i       = 1'b0;
    sq.brlt_i       = 1'b0;
    sq.target_i     = 32'd0;
    sq.ex_valid_i   = 1'b0;
    sq.stall_i      = 1'b0;
    sq.imem_ready_i = 1'b1;
  endtask

  task automatic drive_jump(input logic [6:0] op, input logic [31:0] tgt);
    drive_idle();
    sq.opcode_i   = op;
    sq.target_i   = tgt;
    sq.ex_valid_i = 1'b1;
  endtask

  // Taken redirect from RUN followed by its bubble cycle, with model update.
  task automatic do_redirect(input string name, input logic [6:0] op, input logic [31:0] tgt);
    drive_jump(op, tgt);
    cyc();
    m_pc = {tgt[31:2], 2'b00};
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    chk({name, "_pc"}, sq.pc_o, m_pc);
    chk({name, "_flush"}, {31'd0, sq.flush_o}, 32'd1);
    chk({name, "_cnt"}, {16'd0, sq.taken_cnt_o}, {16'd0, m_cnt});
    drive_idle();
    cyc();
    chk({name, "_bubble_exit"}, {30'd0, state}, {30'd0, S_RUN});
  endtask

  initial begin
    vecs[0]  = '{"beq_t",   OP_B,    3'b000, 1'b1, 1'b0, 1'b1, 32'h0100_0040, 1'b1};
    vecs[1]  = '{"beq_nt",  OP_B,    3'b000, 1'b0, 1'b0, 1'b1, 32'h0100_0800, 1'b0};
    vecs[2]  = '{"bne_t",   OP_B,    3'b001, 1'b0, 1'b1, 1'b1, 32'h0100_0100, 1'b1};
    vecs[3]  = '{"bne_nt",  OP_B,    3'b001, 1'b1, 1'b0, 1'b1, 32'h0100_0800, 1'b0};
    vecs[4]  = '{"blt_t",   OP_B,    3'b100, 1'b0, 1'b1, 1'b1, 32'h0100_0200, 1'b1};
    vecs[5]  = '{"blt_nt",  OP_B,    3'b100, 1'b1, 1'b0, 1'b1, 32'h0100_0800, 1'b0};
    vecs[6]  = '{"bge_t",   OP_B,    3'b101, 1'b1, 1'b0, 1'b1, 32'h0100_0300, 1'b1};
    vecs[7]  = '{"bge_nt",  OP_B,    3'b101, 1'b0, 1'b1, 1'b1, 32'h0100_0800, 1'b0};
    vecs[8]  = '{"bltu_t",  OP_B,    3'b110, 1'b0, 1'b1, 1'b1, 32'h0100_0400, 1'b1};
    vecs[9]  = '{"bgeu_nt", OP_B,    3'b111, 1'b0, 1'b1, 1'b1, 32'h0100_0800, 1'b0};
    vecs[10] = '{"f3_010",  OP_B,    3'b010, 1'b1, 1'b1, 1'b1, 32'h0100_0800, 1'b0};
    vecs[11] = '{"f3_011",  OP_B,    3'b011, 1'b1, 1'b1, 1'b1, 32'h0100_0800, 1'b0};
    vecs[12] = '{"jal",     OP_JAL,  3'b000, 1'b0, 1'b0, 1'b1, 32'h0100_0500, 1'b1};
    vecs[13] = '{"jalr",    OP_JALR, 3'b000, 1'b0, 1'b0, 1'b1, 32'h0100_0600, 1'b1};
    vecs[14] = '{"alu",     OP_ALU,  3'b000, 1'b1, 1'b1, 1'b1, 32'h0100_0800, 1'b0};
    vecs[15] = '{"beq_inv", OP_B,    3'b000, 1'b1, 1'b0, 1'b0, 32'h0100_0800, 1'b0};

    // Reset and boot
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {30'd0, state}, {30'd0, S_BOOT});
    chk("rst_pc", sq.pc_o, RST_PC);
    chk("rst_req", {31'd0, sq.imem_req_o}, 32'd0);
    chk("rst_flush", {31'd0, sq.flush_o}, 32'd0);
    chk("rst_mis", {31'd0, sq.misalign_o}, 32'd0);
    chk("rst_cnt", {16'd0, sq.taken_cnt_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("boot_req", {31'd0, sq.imem_req_o}, 32'd0);
    cyc();
    chk("boot_run", {30'd0, state}, {30'd0, S_RUN});
    chk("boot_pc0", sq.pc_o, 32'h0100_0000);
    chk("boot_req1", {31'd0, sq.imem_req_o}, 32'd1);
    cyc();
    chk("boot_pc1", sq.pc_o, 32'h0100_0004);
    cyc();
    chk("boot_pc2", sq.pc_o, 32'h0100_0008);
    m_pc  = 32'h0100_0008;
    m_cnt = 16'd0;

    // Branch decode table
    for (int i = 0; i < 16; i++) begin
      drive_idle();
      sq.opcode_i   = vecs[i].opcode;
      sq.funct3_i   = vecs[i].funct3;
      sq.breq_i     = vecs[i].breq;
      sq.brlt_i     = vecs[i].brlt;
      sq.ex_valid_i = vecs[i].ex_valid;
      sq.target_i   = vecs[i].target;
      #1;
      chk({vecs[i].name, "_req"}, {31'd0, sq.imem_req_o}, 32'd1);
      cyc();
      if (vecs[i].exp_taken) begin
        m_pc  = vecs[i].target;
        m_cnt = m_cnt + 16'd1;
        chk({vecs[i].name, "_pc"}, sq.pc_o, m_pc);
        chk({vecs[i].name, "_flush"}, {31'd0, sq.flush_o}, 32'd1);
        chk({vecs[i].name, "_state"}, {30'd0, state}, {30'd0, S_BUB});
        chk({vecs[i].name, "_bub_req"}, {31'd0, sq.imem_req_o}, 32'd0);
        chk({vecs[i].name, "_cnt"}, {16'd0, sq.taken_cnt_o}, {16'd0, m_cnt});
        cyc();
        chk({vecs[i].name, "_bub_pc"}, sq.pc_o, m_pc);
        chk({vecs[i].name, "_bub_flush"}, {31'd0, sq.flush_o}, 32'd0);
        chk({vecs[i].name, "_bub_cnt"}, {16'd0, sq.taken_cnt_o}, {16'd0, m_cnt});
        chk({vecs[i].name, "_bub_run"}, {30'd0, state}, {30'd0, S_RUN});
      end else begin
        m_pc = m_pc + 32'd4;
        chk({vecs[i].name, "_pc"}, sq.pc_o, m_pc);
        chk({vecs[i].name, "_flush"}, {31'd0, sq.flush_o}, 32'd0);
        chk({vecs[i].name, "_cnt"}, {16'd0, sq.taken_cnt_o}, {16'd0, m_cnt});
      end
      chk({vecs[i].name, "_mis"}, {31'd0, sq.misalign_o}, 32'd0);
    end

    // Stall and imem backpressure at 0x01000010
    do_redirect("to_10", OP_JAL, 32'h0100_0010);
    sq.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_req", {31'd0, sq.imem_req_o}, 32'd0);
      cyc();
      chk("stall_pc", sq.pc_o, 32'h0100_0010);
    end
    sq.stall_i = 1'b0;
    #1;
    chk("unstall_req", {31'd0, sq.imem_req_o}, 32'd1);
    cyc();
    chk("unstall_pc", sq.pc_o, 32'h0100_0014);
    sq.imem_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("nrdy_req", {31'd0, sq.imem_req_o}, 32'd1);
      cyc();
      chk("nrdy_pc", sq.pc_o, 32'h0100_0014);
    end
    sq.imem_ready_i = 1'b1;
    m_pc = 32'h0100_0014;

    // BGE taken with stall in the same cycle: redirect wins
    drive_idle();
    sq.opcode_i   = OP_B;
    sq.funct3_i   = 3'b101;
    sq.brlt_i     = 1'b0;
    sq.stall_i    = 1'b1;
    sq.ex_valid_i = 1'b1;
    sq.target_i   = 32'h0100_0080;
    cyc();
    m_cnt = m_cnt + 16'd1;
    chk("bge_stall_pc", sq.pc_o, 32'h0100_0080);
    chk("bge_stall_state", {30'd0, state}, {30'd0, S_BUB});
    chk("bge_stall_flush", {31'd0, sq.flush_o}, 32'd1);
    drive_idle();
    cyc();

    // Misaligned JALR target: aligned PC, sticky flag
    drive_jump(OP_JALR, 32'h0100_0023);
    cyc();
    m_cnt = m_cnt + 16'd1;
    chk("jalr_mis_pc", sq.pc_o, 32'h0100_0020);
    chk("jalr_mis_flag", {31'd0, sq.misalign_o}, 32'd1);
    drive_idle();
    cyc();
    cyc();
    chk("mis_sticky1", {31'd0, sq.misalign_o}, 32'd1);
    do_redirect("aligned_after_mis", OP_JAL, 32'h0100_0100);
    chk("mis_sticky2", {31'd0, sq.misalign_o}, 32'd1);

    // PC wrap modulo 2^32
    do_redirect("to_top", OP_JAL, 32'hFFFF_FFFC);
    cyc();
    chk("pc_wrap", sq.pc_o, 32'h0000_0000);

    // Counter saturation from a preloaded value
    drive_idle();
    force dut.cnt_q = 16'hFFFD;
    cyc();
    release dut.cnt_q;
    m_cnt = 16'hFFFD;
    chk("cnt_preload", {16'd0, sq.taken_cnt_o}, {16'd0, m_cnt});
    do_redirect("sat_a", OP_JAL, 32'h0100_0200);
    do_redirect("sat_b", OP_JAL, 32'h0100_0204);
    do_redirect("sat_c", OP_JAL, 32'h0100_0208);
    chk("cnt_saturated", {16'd0, sq.taken_cnt_o}, 32'h0000_FFFF);

    // Reset asserted mid-BUBBLE acts immediately and discards the flush
    drive_jump(OP_JAL, 32'h0100_0300);
    cyc();
    chk("pre_rst_state", {30'd0, state}, {30'd0, S_BUB});
    rst_n = 1'b0;
    #1;
    chk("arst_state", {30'd0, state}, {30'd0, S_BOOT});
    chk("arst_pc", sq.pc_o, RST_PC);
    chk("arst_req", {31'd0, sq.imem_req_o}, 32'd0);
    chk("arst_flush", {31'd0, sq.flush_o}, 32'd0);
    chk("arst_mis", {31'd0, sq.misalign_o}, 32'd0);
    chk("arst_cnt", {16'd0, sq.taken_cnt_o}, 32'd0);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("rerun_state", {30'd0, state}, {30'd0, S_RUN});
    chk("rerun_pc", sq.pc_o, RST_PC);
    chk("rerun_flush", {31'd0, sq.flush_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
